shadow_stack_ctrl: RTL and testbench

Sequencer for the return-address shadow stack in the commit path. Takes committed call/return events from the commit stage one at a time, issues push/pop commands to the register-based shadow stack, compares each popped return address against the actual return target, and raises a sticky violation for the trap logic. The block sits between commit and the shadow stack instance. It also owns the overflow/underflow policy.

---
 rtl/ss_pkg.sv | 25 ++
 rtl/shadow_stack_ctrl.sv | 164 ++++++++++++++++
 tb/tb_shadow_stack_ctrl.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/ss_pkg.sv
// Shared types for the return-address shadow stack sequencer.
//   ss_kind_e  : commit event kind (CALL/RET)
//   ss_cause_e : violation cause code as presented on o_cause
//   ss_state_e : sequencer FSM state
package ss_pkg;

  typedef enum logic {
    KIND_CALL = 1'b0,
    KIND_RET  = 1'b1
  } ss_kind_e;

  typedef enum logic [1:0] {
    CAUSE_NONE      = 2'b00,
    CAUSE_MISMATCH  = 2'b01,
    CAUSE_OVERFLOW  = 2'b10,
    CAUSE_UNDERFLOW = 2'b11
  } ss_cause_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_VIOL = 2'd2
  } ss_state_e;

endpackage

// File: rtl/shadow_stack_ctrl.sv
// shadow_stack_ctrl: sequences committed CALL/RET events onto a register-based
// shadow stack, checks popped return addresses and holds a sticky violation.
//
// Ports
//   clk, rstn                 clock, synchronous active-low reset
//   i_enable                  CSR enable, sampled at handshake only
//   i_valid/o_ready           event handshake (one event per two cycles)
//   i_kind, i_addr            event kind (0 CALL, 1 RET) and address
//   o_push, o_push_data       push command to the stack
//   o_pop, i_pop_data         pop command / combinational top-of-stack
//   i_full, i_empty           stack status
//   i_clear                   clears a held violation (VIOL state only)
//   o_violation, o_cause      sticky violation flag and cause
//   o_viol_expected/_target   popped vs actual address captured at violation
//   o_untracked               saturating count of CALLs lost to overflow
//
// Build option: SHADOW_STACK_STRICT_EN -- when defined, overflow and underflow
// raise violations and the untracked counter never increments.
module shadow_stack_ctrl
  import ss_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_enable,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic             i_kind,
  input  logic [XLEN-1:0]  i_addr,
  output logic             o_push,
  output logic [XLEN-1:0]  o_push_data,
  output logic             o_pop,
  input  logic [XLEN-1:0]  i_pop_data,
  input  logic             i_full,
  input  logic             i_empty,
  input  logic             i_clear,
  output logic             o_violation,
  output logic [1:0]       o_cause,
  output logic [XLEN-1:0]  o_viol_expected,
  output logic [XLEN-1:0]  o_viol_target,
  output logic [CNT_W-1:0] o_untracked
);

  ss_state_e        r_state, w_state_n;
  ss_kind_e         r_kind;
  logic [XLEN-1:0]  r_addr;
  logic [CNT_W-1:0] r_untracked;
  logic             r_violation;
  ss_cause_e        r_cause;
  logic [XLEN-1:0]  r_viol_expected;
  logic [XLEN-1:0]  r_viol_target;

  logic             w_ready, w_push, w_pop;
  logic             w_raise, w_cnt_inc, w_cnt_dec;
  ss_cause_e        w_cause;
  logic [XLEN-1:0]  w_exp;
  logic             w_accept;

  always_ff @(posedge clk) begin
    if (!rstn) r_state <= ST_IDLE;
    else       r_state <= w_state_n;
  end

  always_comb begin
    w_state_n = r_state;
    w_ready   = 1'b0;
    w_push    = 1'b0;
    w_pop     = 1'b0;
    w_raise   = 1'b0;
    w_cause   = CAUSE_NONE;
    w_exp     = '0;
    w_cnt_inc = 1'b0;
    w_cnt_dec = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_ready = 1'b1;
        if (i_valid && i_enable) w_state_n = ST_EXEC;
      end
      ST_EXEC: begin
        w_state_n = ST_IDLE;
        if (r_kind == KIND_CALL) begin
          if (!i_full) begin
            w_push = 1'b1;
          end else begin
`ifdef SHADOW_STACK_STRICT_EN
            w_raise = 1'b1;
            w_cause = CAUSE_OVERFLOW;
`else
            w_cnt_inc = (r_untracked != '1);
`endif
          end
        end else if (r_untracked != '0) begin
          // A RET that pairs with an untracked CALL: nothing to check against.
          w_cnt_dec = 1'b1;
        end else if (i_empty) begin
`ifdef SHADOW_STACK_STRICT_EN
          w_raise = 1'b1;
          w_cause = CAUSE_UNDERFLOW;
`endif
        end else begin
          // Pop is issued even on mismatch so the stack stays aligned.
          w_pop = 1'b1;
          if (i_pop_data != r_addr) begin
            w_raise = 1'b1;
            w_cause = CAUSE_MISMATCH;
            w_exp   = i_pop_data;
          end
        end
        if (w_raise) w_state_n = ST_VIOL;
      end
      ST_VIOL: begin
        w_ready = 1'b1;
        if (i_clear) w_state_n = ST_IDLE;
      end
      default: w_state_n = ST_IDLE;
    endcase
  end

  assign w_accept = (r_state == ST_IDLE) && i_valid && i_enable;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_kind          <= KIND_CALL;
      r_addr          <= '0;
      r_untracked     <= '0;
      r_violation     <= 1'b0;
      r_cause         <= CAUSE_NONE;
      r_viol_expected <= '0;
      r_viol_target   <= '0;
    end else begin
      if (w_accept) begin
        r_kind <= ss_kind_e'(i_kind);
        r_addr <= i_addr;
      end
      if (w_raise) begin
        r_violation     <= 1'b1;
        r_cause         <= w_cause;
        r_viol_expected <= w_exp;
        r_viol_target   <= r_addr;
      end else if (r_state == ST_VIOL && i_clear) begin
        r_violation     <= 1'b0;
        r_cause         <= CAUSE_NONE;
        r_viol_expected <= '0;
        r_viol_target   <= '0;
      end
      if (w_cnt_inc)      r_untracked <= r_untracked + 1'b1;
      else if (w_cnt_dec) r_untracked <= r_untracked - 1'b1;
    end
  end

  // Gated with rstn so a reset landing mid-EXEC issues no stack command.
  assign o_ready         = rstn & w_ready;
  assign o_push          = rstn & w_push;
  assign o_pop           = rstn & w_pop;
  assign o_push_data     = w_push ? r_addr : '0;
  assign o_violation     = r_violation;
  assign o_cause         = r_cause;
  assign o_viol_expected = r_viol_expected;
  assign o_viol_target   = r_viol_target;
  assign o_untracked     = r_untracked;

endmodule

// File: tb/tb_shadow_stack_ctrl.sv
// Self-checking bench for shadow_stack_ctrl with a behavioural depth-8 stack.
// Expected stack commands are queued as each event is driven and compared as
// the DUT issues them; status outputs are checked directly after each event.
module tb_shadow_stack_ctrl;

  localparam int XLEN  = 64;
  localparam int CNT_W = 8;
  localparam int DEPTH = 8;

  logic             clk = 1'b0;
  logic             rstn;
  logic             i_enable, i_valid, i_kind, i_clear;
  logic [XLEN-1:0]  i_addr;
  logic             o_ready, o_push, o_pop;
  logic [XLEN-1:0]  o_push_data, i_pop_data;
  logic             i_full, i_empty;
  logic             o_violation;
  logic [1:0]       o_cause;
  logic [XLEN-1:0]  o_viol_expected, o_viol_target;
  logic [CNT_W-1:0] o_untracked;

  shadow_stack_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rstn(rstn), .i_enable(i_enable), .i_valid(i_valid),
    .o_ready(o_ready), .i_kind(i_kind), .i_addr(i_addr),
    .o_push(o_push), .o_push_data(o_push_data), .o_pop(o_pop),
    .i_pop_data(i_pop_data), .i_full(i_full), .i_empty(i_empty),
    .i_clear(i_clear), .o_violation(o_violation), .o_cause(o_cause),
    .o_viol_expected(o_viol_expected), .o_viol_target(o_viol_target),
    .o_untracked(o_untracked)
  );

  always #5 clk = ~clk;

  // behavioural stack
  logic [XLEN-1:0] mem [DEPTH];
  int sp;
  always_comb begin
    i_full     = (sp == DEPTH);
    i_empty    = (sp == 0);
    i_pop_data = (sp == 0) ? '0 : mem[sp-1];
  end
  always @(posedge clk) begin
    if (!rstn) sp <= 0;
    else if (o_push && sp < DEPTH) begin mem[sp] <= o_push_data; sp <= sp + 1; end
    else if (o_pop && sp > 0) sp <= sp - 1;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct { logic is_push; logic [XLEN-1:0] data; } cmd_t;
  cmd_t exp_q[$];

  task automatic exp_push(input logic [XLEN-1:0] a);
    cmd_t c; c.is_push = 1'b1; c.data = a; exp_q.push_back(c);
  endtask
  task automatic exp_pop(input logic [XLEN-1:0] a);
    cmd_t c; c.is_push = 1'b0; c.data = a; exp_q.push_back(c);
  endtask

  // scoreboard consumer
  always @(negedge clk) begin
    if (o_push || o_pop) begin
      chk("cmd_excl", 64'(o_push & o_pop), 64'd0);
      if (exp_q.size() == 0) begin
        chk("unexp_cmd", 64'({o_push, o_pop}), 64'd0);
      end else begin
        cmd_t c;
        c = exp_q.pop_front();
        chk("cmd_kind", 64'(o_push), 64'(c.is_push));
        chk("cmd_data", o_push ? o_push_data : i_pop_data, c.data);
      end
    end
  end

  // Drives one event at a negedge once ready; returns at the negedge of N+2.
  // i_enable drops during EXEC to show the latched event still completes.
  task automatic send(input logic kind, input logic [XLEN-1:0] a, input logic en);
    int t;
    t = 0;
    while (!o_ready && t < 20) begin @(negedge clk); t++; end
    if (!o_ready) chk("ready_timeout", 64'(o_ready), 64'd1);
    i_valid = 1'b1; i_kind = kind; i_addr = a; i_enable = en;
    @(posedge clk); #1;
    i_valid = 1'b0; i_enable = 1'b0;
    @(negedge clk);
    @(negedge clk);
    i_enable = 1'b1;
  endtask

  task automatic clear_viol();
    i_clear = 1'b1; i_valid = 1'b1; i_kind = 1'b0; i_addr = 64'h99;
    @(posedge clk); #1;
    i_clear = 1'b0; i_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rstn = 1'b0; i_enable = 1'b1; i_valid = 1'b0; i_kind = 1'b0;
    i_addr = '0; i_clear = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(o_ready), 64'd0);
    chk("rst_push",  64'(o_push | o_pop), 64'd0);
    chk("rst_viol",  64'(o_violation), 64'd0);
    rstn = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 64'(o_ready), 64'd1);
    chk("post_rst_cause", 64'(o_cause), 64'd0);
    chk("post_rst_untr",  64'(o_untracked), 64'd0);

    // matched call/return
    exp_push(64'h1000); send(1'b0, 64'h1000, 1'b1);
    exp_pop(64'h1000);  send(1'b1, 64'h1000, 1'b1);
    chk("match_viol",  64'(o_violation), 64'd0);
    chk("match_empty", 64'(i_empty), 64'd1);

    // mismatch
    exp_push(64'h1000); send(1'b0, 64'h1000, 1'b1);
    exp_pop(64'h1000);  send(1'b1, 64'h2000, 1'b1);
    chk("mm_viol",   64'(o_violation), 64'd1);
    chk("mm_cause",  64'(o_cause), 64'd1);
    chk("mm_exp",    o_viol_expected, 64'h1000);
    chk("mm_tgt",    o_viol_target, 64'h2000);
    send(1'b0, 64'h55, 1'b1);      // dropped in VIOL
    chk("viol_ready", 64'(o_ready), 64'd1);
    chk("viol_hold",  64'(o_cause), 64'd1);
    clear_viol();
    chk("clr_viol",  64'(o_violation), 64'd0);
    chk("clr_cause", 64'(o_cause), 64'd0);
    chk("clr_exp",   o_viol_expected, 64'd0);
    chk("clr_tgt",   o_viol_target, 64'd0);
    chk("clr_ready", 64'(o_ready), 64'd1);

    // overflow: 9 calls into a depth-8 stack
    for (int i = 0; i < 9; i++) begin
      if (i < DEPTH) exp_push(64'h100 + 64'(i * 4));
      send(1'b0, 64'h100 + 64'(i * 4), 1'b1);
    end
`ifdef SHADOW_STACK_STRICT_EN
    chk("ovf_viol",  64'(o_violation), 64'd1);
    chk("ovf_cause", 64'(o_cause), 64'd2);
    chk("ovf_exp",   o_viol_expected, 64'd0);
    chk("ovf_tgt",   o_viol_target, 64'h120);
    chk("ovf_untr",  64'(o_untracked), 64'd0);
    clear_viol();
`else
    chk("ovf_untr",  64'(o_untracked), 64'd1);
    chk("ovf_viol",  64'(o_violation), 64'd0);
    send(1'b1, 64'h120, 1'b1);     // consumes the untracked entry, no pop
    chk("ovf_dec",   64'(o_untracked), 64'd0);
`endif
    for (int i = DEPTH - 1; i >= 0; i--) begin
      exp_pop(64'h100 + 64'(i * 4));
      send(1'b1, 64'h100 + 64'(i * 4), 1'b1);
    end
    chk("ovf_ret_viol",  64'(o_violation), 64'd0);
    chk("ovf_ret_empty", 64'(i_empty), 64'd1);

    // underflow
    send(1'b1, 64'h77, 1'b1);
`ifdef SHADOW_STACK_STRICT_EN
    chk("udf_viol",  64'(o_violation), 64'd1);
    chk("udf_cause", 64'(o_cause), 64'd3);
    chk("udf_exp",   o_viol_expected, 64'd0);
    chk("udf_tgt",   o_viol_target, 64'h77);
    clear_viol();
`else
    chk("udf_viol",  64'(o_violation), 64'd0);
    chk("udf_cause", 64'(o_cause), 64'd0);
`endif

    // disabled: accepted and dropped, ready every cycle
    i_valid = 1'b1; i_kind = 1'b0; i_addr = 64'h40; i_enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("dis_ready", 64'(o_ready), 64'd1);
    end
    i_valid = 1'b0; i_enable = 1'b1;
    chk("dis_empty", 64'(i_empty), 64'd1);

    // reset during the EXEC cycle of a RET
    exp_push(64'h300); send(1'b0, 64'h300, 1'b1);
    i_valid = 1'b1; i_kind = 1'b1; i_addr = 64'h300;
    @(posedge clk); #1;
    i_valid = 1'b0; rstn = 1'b0;
    @(negedge clk);
    chk("rexec_pop",   64'(o_pop), 64'd0);
    chk("rexec_ready", 64'(o_ready), 64'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(negedge clk);
    chk("rexec_idle", 64'(o_ready), 64'd1);
    chk("rexec_pop2", 64'(o_pop), 64'd0);
    @(negedge clk);

    chk("sb_drain", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
